scoreboard: RTL and testbench
=============================

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default NR_SB_ENTRIES (4), meaning the number of in-flight instruction slots.
REQ-002 SHALL have parameter NR_WB_PORTS, default NR_WB_PORTS (3), meaning the number of writeback ports.
REQ-003 SHALL have one clock and an asynchronous active-low reset; the ports are clk_i and rst_ni.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  discard all entries.
REQ-007 full_o  out  1  no free slot.
REQ-008 decoded_instr_i  in  scoreboard_entry  instruction from issue.
REQ-009 decoded_instr_valid_i  in  1  issue request.
REQ-010 decoded_instr_ack_o  out  1  instruction accepted this cycle.
REQ-011 issue_trans_id_o  out  TRANS_ID_BITS  slot assigned to the current issue (tail pointer).
REQ-012 rs1_i, rs2_i  in  5 each  source-register query.
REQ-013 rs1_busy_o, rs2_busy_o  out  1 each  pending writer exists.
REQ-014 trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback target.
REQ-015 wdata_i  in  NR_WB_PORTS x 64  writeback result.
REQ-016 ex_i  in  NR_WB_PORTS x exception  writeback exception.
REQ-017 wb_valid_i  in  NR_WB_PORTS x 1  writeback strobe.
REQ-018 commit_instr_o  out  scoreboard_entry  head entry.
REQ-019 commit_valid_o  out  1  head is occupied and complete.
REQ-020 commit_ack_i  in  1  commit consumed the head.

Function
REQ-021 SHALL be a circular buffer: head and tail pointers of TRANS_ID_BITS wrap modulo NR_ENTRIES; the count register is $clog2(NR_ENTRIES)+1 bits wide.
REQ-022 full_o SHALL equal (count == NR_ENTRIES), taken from the registered count with no same-cycle commit bypass.
REQ-023 decoded_instr_ack_o SHALL be combinational: decoded_instr_valid_i & !full_o & !flush_i.
REQ-024 On ack, the slot at tail SHALL store decoded_instr_i with trans_id = tail and valid = decoded_instr_i.ex.valid; the result field keeps the immediate; tail increments.
REQ-025 Each port with wb_valid_i set SHALL, on the next edge, set the entry's result to wdata_i and valid to 1; if ex_i.valid is set, it SHALL also overwrite the entry's ex field.
REQ-026 A writeback to an unoccupied slot SHALL be ignored; when several ports target the same trans_id in one cycle, the highest-indexed port SHALL win.
REQ-027 commit_valid_o SHALL equal (count != 0) & entry[head].valid, using registered state only.
REQ-028 commit_instr_o SHALL present entry[head] combinationally.
REQ-029 commit_ack_i while commit_valid_o is set SHALL advance head and clear the slot; commit_ack_i without commit_valid_o SHALL be ignored.
REQ-030 When issue and commit occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-031 rsX_busy_o SHALL be 1 when any occupied entry has rd == rsX_i, otherwise 0; it SHALL be 0 when rsX_i == 0.
REQ-032 flush_i SHALL zero head, tail, count and all occupancy/valid bits on the next edge, with priority over issue, writeback and commit in the same cycle.

Reset
REQ-033 Asynchronous assertion of rst_ni SHALL clear the head, tail and count registers and every entry to 0.
REQ-034 Outputs after reset: full_o=0, commit_valid_o=0, commit_instr_o all zeros, issue_trans_id_o=0, both busy outputs=0; decoded_instr_ack_o follows REQ-023.
REQ-035 Reset asserted during operation SHALL drop all in-flight entries without producing a commit.

Structure
REQ-036 scoreboard_entry, exception, TRANS_ID_BITS, NR_SB_ENTRIES and NR_WB_PORTS SHALL come from ariane_pkg; the block adds no new shared types.
REQ-037 The block SHALL have no sub-modules; it is a single module with registered entry array, pointers and count.

Verification
REQ-038 Issue 4 instructions with rd=1,2,3,4 -> ack on each; full_o=1 after the 4th; a 5th request gets ack=0; issue_trans_id_o sequence 0,1,2,3.
REQ-039 Writeback to trans_id 2 with 0xDEAD, then trans_id 0 with 0xBEEF -> commit_valid_o rises only after trans_id 0 is written; the first commit has result 0xBEEF.
REQ-040 While full, issue and commit in the same cycle -> issue is rejected; the next cycle full_o=0 and the issue is accepted with trans_id 0 (wrap-around).
REQ-041 Ports 0 and 2 write trans_id 1 with 0x11 and 0x22 in the same cycle -> the entry holds 0x22.
REQ-042 A decoded entry with ex.valid=1 and cause ILLEGAL_INSTR -> commit_valid_o=1 the next cycle with no writeback; ex.cause=2.
REQ-043 Three entries in flight, then flush_i together with wb_valid_i and commit_ack_i -> count=0, commit_valid_o=0, both busy outputs=0; the next issue gets trans_id 0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types used by the scoreboard and its neighbours.
//   NR_SB_ENTRIES : number of in-flight instruction slots
//   TRANS_ID_BITS : width of a transaction id (slot index)
//   NR_WB_PORTS   : number of functional-unit writeback ports
//   exception     : cause / tval / valid triple carried with an instruction
//   scoreboard_entry : decoded instruction as tracked by the scoreboard
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  // Exception cause codes (RISC-V mcause encoding).
  localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
  localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
  localparam logic [63:0] BREAKPOINT            = 64'd3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef enum logic [2:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, XORL, SLL, SRL, SRA, LD, SD, JALR, MUL, CSRRW
  } fu_op;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    fu_op                     op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;  // immediate at issue, result after writeback
    logic                     valid;   // result (or exception) is available
    logic                     use_imm;
    logic                     use_pc;
    exception                 ex;
    logic                     is_compressed;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order scoreboard: a circular buffer of in-flight instructions.
//   clk_i / rst_ni          : clock, asynchronous active-low reset
//   flush_i                 : discard every in-flight entry
//   full_o                  : no free slot
//   decoded_instr_*         : issue request / entry / acknowledge
//   issue_trans_id_o        : slot the current issue lands in (tail)
//   rs1_i/rs2_i, rsX_busy_o : source-register hazard query
//   trans_id_i, wdata_i,
//   ex_i, wb_valid_i        : per-port writeback of results and exceptions
//   commit_instr_o          : entry at the head
//   commit_valid_o          : head is occupied and complete
//   commit_ack_i            : commit stage consumed the head
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       flush_i,
  output logic                                       full_o,
  input  scoreboard_entry                            decoded_instr_i,
  input  logic                                       decoded_instr_valid_i,
  output logic                                       decoded_instr_ack_o,
  output logic [TRANS_ID_BITS-1:0]                   issue_trans_id_o,
  input  logic [4:0]                                 rs1_i,
  input  logic [4:0]                                 rs2_i,
  output logic                                       rs1_busy_o,
  output logic                                       rs2_busy_o,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]               wdata_i,
  input  exception [NR_WB_PORTS-1:0]                 ex_i,
  input  logic [NR_WB_PORTS-1:0]                     wb_valid_i,
  output scoreboard_entry                            commit_instr_o,
  output logic                                       commit_valid_o,
  input  logic                                       commit_ack_i
);

  localparam int unsigned CNT_W = $clog2(NR_ENTRIES) + 1;

  typedef logic [TRANS_ID_BITS-1:0] ptr_t;

  // Pointers wrap modulo NR_ENTRIES, which need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_inc = (p == ptr_t'(NR_ENTRIES - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
  logic            [NR_ENTRIES-1:0] occ_q, occ_d;   // slot holds an in-flight instruction
  ptr_t                             head_q, head_d;
  ptr_t                             tail_q, tail_d;
  logic            [CNT_W-1:0]      cnt_q, cnt_d;

  logic issue;
  logic commit;

  // Status is derived from registered state only; a commit in the same
  // cycle does not free a slot for an issue.
  assign full_o              = (cnt_q == CNT_W'(NR_ENTRIES));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign issue_trans_id_o    = tail_q;
  assign commit_instr_o      = mem_q[head_q];
  assign commit_valid_o      = (cnt_q != '0) & mem_q[head_q].valid;

  assign issue  = decoded_instr_ack_o;
  assign commit = commit_ack_i & commit_valid_o;

  // Register-hazard lookup: x0 never has a pending writer.
  always_comb begin
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (occ_q[i] && (mem_q[i].rd == rs1_i)) rs1_busy_o = 1'b1;
      if (occ_q[i] && (mem_q[i].rd == rs2_i)) rs2_busy_o = 1'b1;
    end
    if (rs1_i == '0) rs1_busy_o = 1'b0;
    if (rs2_i == '0) rs2_busy_o = 1'b0;
  end

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no
    // path through this block leaves a signal unassigned (no latches).
    mem_d  = mem_q;
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    if (issue) begin
      mem_d[tail_q]          = decoded_instr_i;
      mem_d[tail_q].trans_id = tail_q;
      // An instruction that already faulted in decode is complete.
      mem_d[tail_q].valid    = decoded_instr_i.ex.valid;
      occ_d[tail_q]          = 1'b1;
      tail_d                 = ptr_inc(tail_q);
    end

    // Later ports overwrite earlier ones, so the highest index wins.
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && occ_q[trans_id_i[p]]) begin
        mem_d[trans_id_i[p]].result = wdata_i[p];
        mem_d[trans_id_i[p]].valid  = 1'b1;
        if (ex_i[p].valid) mem_d[trans_id_i[p]].ex = ex_i[p];
      end
    end

    if (commit) begin
      mem_d[head_q] = '0;
      occ_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end

    cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(commit);

    // Flush overrides everything computed above.
    if (flush_i) begin
      mem_d  = '0;
      occ_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the entry array is reset, not just the occupancy bits: the
      // head entry is visible on commit_instr_o and must read as zero.
      mem_q  <= '0;
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every
      // register samples the pre-edge value of the others.
      mem_q  <= mem_d;
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the in-flight instructions.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N = NR_SB_ENTRIES;
  localparam int P = NR_WB_PORTS;

  logic                                   clk_i = 1'b0;
  logic                                   rst_ni;
  logic                                   flush_i;
  logic                                   full_o;
  scoreboard_entry                        decoded_instr_i;
  logic                                   decoded_instr_valid_i;
  logic                                   decoded_instr_ack_o;
  logic [TRANS_ID_BITS-1:0]               issue_trans_id_o;
  logic [4:0]                             rs1_i, rs2_i;
  logic                                   rs1_busy_o, rs2_busy_o;
  logic [P-1:0][TRANS_ID_BITS-1:0]        trans_id_i;
  logic [P-1:0][63:0]                     wdata_i;
  exception [P-1:0]                       ex_i;
  logic [P-1:0]                           wb_valid_i;
  scoreboard_entry                        commit_instr_o;
  logic                                   commit_valid_o;
  logic                                   commit_ack_i;

  scoreboard dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .full_o                (full_o),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_trans_id_o      (issue_trans_id_o),
    .rs1_i                 (rs1_i),
    .rs2_i                 (rs2_i),
    .rs1_busy_o            (rs1_busy_o),
    .rs2_busy_o            (rs2_busy_o),
    .trans_id_i            (trans_id_i),
    .wdata_i               (wdata_i),
    .ex_i                  (ex_i),
    .wb_valid_i            (wb_valid_i),
    .commit_instr_o        (commit_instr_o),
    .commit_valid_o        (commit_valid_o),
    .commit_ack_i          (commit_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Model: in-flight instructions oldest first; m_head is the slot of q[0].
  scoreboard_entry q[$];
  int              m_head = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic scoreboard_entry mk(input logic [4:0] rd, input logic exv,
                                         input logic [63:0] cause, input logic [63:0] imm);
    scoreboard_entry e;
    e               = '0;
    e.pc            = {$urandom, $urandom};
    e.trans_id      = TRANS_ID_BITS'($urandom);
    e.fu            = fu_t'($urandom_range(0, 6));
    e.op            = fu_op'($urandom_range(0, 12));
    e.rs1           = 5'($urandom);
    e.rs2           = 5'($urandom);
    e.rd            = rd;
    e.result        = imm;
    e.valid         = 1'($urandom);
    e.use_imm       = 1'($urandom);
    e.use_pc        = 1'($urandom);
    e.ex.cause      = cause;
    e.ex.tval       = {$urandom, $urandom};
    e.ex.valid      = exv;
    e.is_compressed = 1'($urandom);
    return e;
  endfunction

  task automatic idle();
    flush_i               = 1'b0;
    decoded_instr_valid_i = 1'b0;
    decoded_instr_i       = '0;
    rs1_i                 = '0;
    rs2_i                 = '0;
    trans_id_i            = '0;
    wdata_i               = '0;
    ex_i                  = '0;
    wb_valid_i            = '0;
    commit_ack_i          = 1'b0;
  endtask

  // Compare every DUT output against what the model says it must be.
  task automatic compare();
    int              sz;
    scoreboard_entry head_e;
    logic            b1, b2;
    sz     = q.size();
    head_e = '0;
    b1     = 1'b0;
    b2     = 1'b0;
    if (sz > 0) head_e = q[0];
    foreach (q[i]) begin
      if (rs1_i != 0 && q[i].rd == rs1_i) b1 = 1'b1;
      if (rs2_i != 0 && q[i].rd == rs2_i) b2 = 1'b1;
    end
    check("full", 512'(full_o), 512'(sz == N));
    check("ack", 512'(decoded_instr_ack_o), 512'(decoded_instr_valid_i && sz < N && !flush_i));
    check("issue_id", 512'(issue_trans_id_o), 512'((m_head + sz) % N));
    check("commit_valid", 512'(commit_valid_o), 512'(sz > 0 && head_e.valid));
    check("commit_instr", 512'(commit_instr_o), 512'(head_e));
    check("rs1_busy", 512'(rs1_busy_o), 512'(b1));
    check("rs2_busy", 512'(rs2_busy_o), 512'(b2));
  endtask

  // Apply one clock edge worth of the rules to the model.
  task automatic model_update();
    int              sz, pos, tail;
    bit              acc, com;
    scoreboard_entry e;
    sz   = q.size();
    tail = (m_head + sz) % N;
    acc  = decoded_instr_valid_i && sz < N && !flush_i;
    com  = commit_ack_i && sz > 0 && q[0].valid;
    if (flush_i) begin
      q.delete();
      m_head = 0;
      return;
    end
    for (int p = 0; p < P; p++) begin
      if (wb_valid_i[p]) begin
        pos = (int'(trans_id_i[p]) - m_head + N) % N;
        if (pos < sz) begin
          e        = q[pos];
          e.result = wdata_i[p];
          e.valid  = 1'b1;
          if (ex_i[p].valid) e.ex = ex_i[p];
          q[pos]   = e;
        end
      end
    end
    if (com) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % N;
    end
    if (acc) begin
      e          = decoded_instr_i;
      e.trans_id = TRANS_ID_BITS'(tail);
      e.valid    = decoded_instr_i.ex.valid;
      q.push_back(e);
    end
  endtask

  // Called at a falling edge once inputs are set.
  task automatic tick();
    #1 compare();
    @(posedge clk_i);
    if (rst_ni) model_update();
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rs1_i = 5'd1;
    rs2_i = 5'd2;
    #1;
    check("rst_full", 512'(full_o), 0);
    check("rst_commit_valid", 512'(commit_valid_o), 0);
    check("rst_commit_instr", 512'(commit_instr_o), 0);
    check("rst_issue_id", 512'(issue_trans_id_o), 0);
    check("rst_busy1", 512'(rs1_busy_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    tick();

    // Fill: four issues, ids 0..3, then full and the fifth is refused.
    for (int k = 1; k <= 4; k++) begin
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = mk(5'(k), 1'b0, 64'd0, 64'(k * 100));
      #1;
      check("fill_ack", 512'(decoded_instr_ack_o), 1);
      check("fill_id", 512'(issue_trans_id_o), 512'(k - 1));
      tick();
    end
    check("full_after_4", 512'(full_o), 1);
    decoded_instr_i = mk(5'd5, 1'b0, 64'd0, 64'd500);
    rs1_i = 5'd3;
    rs2_i = 5'd5;
    #1;
    check("fifth_ack", 512'(decoded_instr_ack_o), 0);
    check("busy_rd3", 512'(rs1_busy_o), 1);
    check("busy_rd5", 512'(rs2_busy_o), 0);
    tick();
    idle();

    // Out-of-order writeback: head completes only when id 0 is written.
    wb_valid_i = 3'b001; trans_id_i[0] = 2'd2; wdata_i[0] = 64'hDEAD;
    tick();
    idle();
    #1 check("cv_after_wb2", 512'(commit_valid_o), 0);
    wb_valid_i = 3'b001; trans_id_i[0] = 2'd0; wdata_i[0] = 64'hBEEF;
    tick();
    idle();
    #1;
    check("cv_after_wb0", 512'(commit_valid_o), 1);
    check("commit_result", 512'(commit_instr_o.result), 64'hBEEF);

    // Full: simultaneous issue + commit refuses the issue; next cycle wraps to id 0.
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = mk(5'd6, 1'b0, 64'd0, 64'd600);
    commit_ack_i          = 1'b1;
    #1 check("full_issue_commit_ack", 512'(decoded_instr_ack_o), 0);
    tick();
    commit_ack_i = 1'b0;
    check("not_full_after_commit", 512'(full_o), 0);
    #1;
    check("wrap_ack", 512'(decoded_instr_ack_o), 1);
    check("wrap_id", 512'(issue_trans_id_o), 0);
    tick();
    idle();

    // Two ports hit id 1 (now the head): the higher port wins.
    wb_valid_i = 3'b101;
    trans_id_i[0] = 2'd1; wdata_i[0] = 64'h11;
    trans_id_i[2] = 2'd1; wdata_i[2] = 64'h22;
    tick();
    idle();
    #1;
    check("multi_wb_valid", 512'(commit_valid_o), 1);
    check("multi_wb_result", 512'(commit_instr_o.result), 64'h22);

    // Commit one, leaving ids 2,3,0 (rd 3,4,6) in flight; then flush with everything else.
    commit_ack_i = 1'b1;
    tick();
    idle();
    rs1_i = 5'd3;
    rs2_i = 5'd6;
    #1;
    check("pre_flush_busy1", 512'(rs1_busy_o), 1);
    check("pre_flush_busy2", 512'(rs2_busy_o), 1);
    flush_i = 1'b1; commit_ack_i = 1'b1; decoded_instr_valid_i = 1'b1;
    decoded_instr_i = mk(5'd9, 1'b0, 64'd0, 64'd900);
    wb_valid_i = 3'b111;
    trans_id_i[0] = 2'd3; trans_id_i[1] = 2'd0; trans_id_i[2] = 2'd2;
    wdata_i[0] = 64'h1; wdata_i[1] = 64'h2; wdata_i[2] = 64'h3;
    #1 check("flush_ack", 512'(decoded_instr_ack_o), 0);
    tick();
    idle();
    rs1_i = 5'd3;
    rs2_i = 5'd6;
    #1;
    check("flush_full", 512'(full_o), 0);
    check("flush_cv", 512'(commit_valid_o), 0);
    check("flush_busy1", 512'(rs1_busy_o), 0);
    check("flush_busy2", 512'(rs2_busy_o), 0);

    // Decoded exception: complete on issue, id 0 after the flush.
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = mk(5'd7, 1'b1, ILLEGAL_INSTR, 64'd0);
    check("post_flush_id", 512'(issue_trans_id_o), 0);
    tick();
    idle();
    #1;
    check("ex_commit_valid", 512'(commit_valid_o), 1);
    check("ex_cause", 512'(commit_instr_o.ex.cause), 2);

    // Asynchronous reset mid-operation drops everything without a commit.
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = mk(5'd8, 1'b0, 64'd0, 64'd800);
    tick();
    idle();
    commit_ack_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    q.delete();
    m_head = 0;
    check("arst_cv", 512'(commit_valid_o), 0);
    check("arst_commit_instr", 512'(commit_instr_o), 0);
    compare();
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    tick();

    // Randomized traffic against the model.
    repeat (3000) begin
      flush_i               = ($urandom_range(0, 49) == 0);
      decoded_instr_valid_i = ($urandom_range(0, 9) < 6);
      decoded_instr_i       = mk(5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                                 64'($urandom_range(0, 15)), {$urandom, $urandom});
      commit_ack_i          = ($urandom_range(0, 1) == 1);
      rs1_i                 = 5'($urandom_range(0, 7));
      rs2_i                 = 5'($urandom_range(0, 7));
      for (int p = 0; p < P; p++) begin
        wb_valid_i[p]  = ($urandom_range(0, 9) < 3);
        trans_id_i[p]  = TRANS_ID_BITS'($urandom);
        wdata_i[p]     = {$urandom, $urandom};
        ex_i[p].cause  = 64'($urandom_range(0, 15));
        ex_i[p].tval   = {$urandom, $urandom};
        ex_i[p].valid  = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
